pkt_hdr_parser: RTL
===================

Name: pkt_hdr_parser

Overview:
- Upstream neighbour of pkt_Priorer. Takes a 64-bit packet word stream with SOP/EOP framing and decodes the header word into a pkHeadInfo descriptor.
- Checks the declared length against the actual beat count.
- Presents one descriptor per good packet on an enqueue strobe that connects directly to pkt_Priorer in_en / in_pkt_info / in_data.
- Drops malformed packets and counts them.

Parameters:
- DWIDTH, 64, stream and payload word width; only 64 is supported.
- MAX_WORDS, 256, maximum packet length in words; the beat counter is $clog2(MAX_WORDS)+1 bits wide.
- CNT_W, 32, width of the saturating drop counter.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  upstream beat valid
- in_ready  out  1  parser can accept a beat
- in_data  in  DWIDTH  stream word
- in_sop  in  1  first word of packet (header word)
- in_eop  in  1  last word of packet
- out_en  out  1  descriptor valid/enqueue strobe; connects to pkt_Priorer in_en
- out_ready  in  1  priorer has space; driven from pkt_Priorer in_valid
- out_pkt_info  out  $bits(pkHeadInfo)  decoded descriptor
- out_data  out  DWIDTH  first payload word (word 1), or 0 for a single-word packet
- drop_cnt  out  CNT_W  saturating count of dropped packets and stray beats

Behaviour:
- Clock/reset: single clock clk; reset rst is synchronous and active-high. Reset overrides everything on the same edge.
- Reset values: in_ready=0, out_en=0, out_pkt_info=0, out_data=0, drop_cnt=0, state=IDLE.
- in_ready rises the cycle after rst deasserts.
- A beat is accepted when in_valid && in_ready.
- Header word fields:
  - [63:48] flow_id
  - [47:40] prio
  - [39:32] src_id
  - [31:24] dst_id
  - [23:8] len, total bytes including the 8-byte header
  - [7:0] chk
- Expected words = (len+7)>>3.
- FSM states: IDLE, BODY, EMIT.
- IDLE:
  - Accepted beat with sop: latch header fields, word_cnt=1.
  - If eop is also set on that beat, evaluate the packet immediately; otherwise go to BODY.
  - Accepted beat without sop: discard it, drop_cnt+1, stay in IDLE.
- BODY:
  - Each accepted beat increments word_cnt. On word_cnt==1 the beat is latched into the out_data register.
  - Beat with sop: the previous packet is truncated. drop_cnt+1, latch the new header, word_cnt=1, remain in BODY (or evaluate immediately if eop is also set).
  - word_cnt reaching MAX_WORDS without eop: drop, discard beats until eop, then go to IDLE.
- Evaluation on the eop beat. The packet is good when len!=0, expected words == final word_cnt, and expected words <= MAX_WORDS.
  - Good packet: go to EMIT; out_en=1 on the next cycle, so latency is 1 cycle from the eop accept.
  - Bad packet: drop_cnt+1, go to IDLE.
- EMIT:
  - in_ready=0.
  - out_en, out_pkt_info and out_data are held stable until out_ready=1.
  - On the edge where out_en && out_ready, the transfer completes. Next cycle: out_en=0, in_ready=1, state IDLE.
  - Back-to-back throughput is therefore one idle cycle per packet.
- drop_cnt saturates at all-ones and never wraps.
- rst mid-packet or in EMIT: the partial packet or pending descriptor is discarded and not counted.
- in_ready is registered; it has no combinational path from out_ready.

Optional Feature:
- Macro: PKT_PARSER_CHKSUM_EN.
- Defined: chk must equal the XOR of header bytes [63:56]..[15:8]. On mismatch the packet is dropped at eop with drop_cnt+1 even if the length is good.
- Undefined: chk is ignored and no checksum logic is synthesised.

Decomposition:
- pkt_h package holds:
  - typedef pkHeadInfo (flow_id 16, prio 8, src_id 8, dst_id 8, len 16)
  - header bit-position localparams
  - parser state enum
- One sub-module: pkt_hdr_chksum (combinational byte-XOR), instantiated only under PKT_PARSER_CHKSUM_EN.

Test Plan:
- Reset check: hold rst 3 cycles -> all outputs 0; in_ready=1 the cycle after rst falls.
- Good 3-word packet: header len=24, prio=5, flow_id=0x1234; out_ready=1 -> out_en pulses 1 cycle, the cycle after eop. out_pkt_info.prio=5, flow_id=0x1234; out_data=word1; drop_cnt=0.
- Length mismatch: len=32 with 3 beats -> no out_en; drop_cnt=1.
- Backpressure: out_ready=0 for 10 cycles after a good packet -> out_en and outputs held stable, in_ready=0; out_ready=1 -> one transfer, then in_ready=1.
- Truncation and stray beat: a sop arrives mid-packet, then a non-sop beat in IDLE -> drop_cnt=2; the second packet is emitted correctly.
- PKT_PARSER_CHKSUM_EN: wrong chk -> dropped, drop_cnt+1. Without the macro, the same stimulus is emitted.

Source files
------------

// File: rtl/pkt_hdr_parser_pkg.sv
`default_nettype none
// ============================================================================
// Module   : pkt_h (package)
// Purpose  : Shared types for pkt_hdr_parser: descriptor, header layout, states.
// Revision : 1.0
// ============================================================================
package pkt_h;

    localparam int c_hdr_flow_msb = 63;
    localparam int c_hdr_flow_lsb = 48;
    localparam int c_hdr_prio_msb = 47;
    localparam int c_hdr_prio_lsb = 40;
    localparam int c_hdr_src_msb  = 39;
    localparam int c_hdr_src_lsb  = 32;
    localparam int c_hdr_dst_msb  = 31;
    localparam int c_hdr_dst_lsb  = 24;
    localparam int c_hdr_len_msb  = 23;
    localparam int c_hdr_len_lsb  = 8;
    localparam int c_hdr_chk_msb  = 7;
    localparam int c_hdr_chk_lsb  = 0;

    typedef struct packed {
        logic [15:0] flow_id;
        logic [7:0]  prio;
        logic [7:0]  src_id;
        logic [7:0]  dst_id;
        logic [15:0] len;
    } pkHeadInfo;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BODY = 2'd1,
        EMIT = 2'd2
    } parser_state_e;

    function automatic pkHeadInfo decode_hdr(input logic [63:0] w);
        pkHeadInfo h;
        h.flow_id = w[c_hdr_flow_msb:c_hdr_flow_lsb];
        h.prio    = w[c_hdr_prio_msb:c_hdr_prio_lsb];
        h.src_id  = w[c_hdr_src_msb:c_hdr_src_lsb];
        h.dst_id  = w[c_hdr_dst_msb:c_hdr_dst_lsb];
        h.len     = w[c_hdr_len_msb:c_hdr_len_lsb];
        return h;
    endfunction

endpackage
`default_nettype wire

// File: rtl/pkt_hdr_parser_chksum.sv
`default_nettype none
// ============================================================================
// Module   : pkt_hdr_chksum
// Purpose  : Header checksum compare (XOR of bytes [63:56]..[15:8] vs [7:0]).
//            Present only when PKT_PARSER_CHKSUM_EN is defined.
// Revision : 1.0
// ============================================================================
`ifdef PKT_PARSER_CHKSUM_EN
module pkt_hdr_chksum
    import pkt_h::*;
(
    input  logic [63:0] i_hdr,
    output logic        o_chk_ok
);

    logic [7:0] w_xor;

    always_comb begin
        w_xor = 8'h00;
        for (int i = 1; i < 8; i++) begin
            w_xor = w_xor ^ i_hdr[i*8 +: 8];
        end
    end

    assign o_chk_ok = (w_xor == i_hdr[c_hdr_chk_msb:c_hdr_chk_lsb]);

endmodule
`endif
`default_nettype wire

// File: rtl/pkt_hdr_parser.sv
`default_nettype none
// ============================================================================
// Module   : pkt_hdr_parser
// Purpose  : Decodes SOP/EOP framed 64-bit packets into pkHeadInfo descriptors,
//            length-checks them and drops/counts malformed ones.
//            Optional header checksum: PKT_PARSER_CHKSUM_EN.
// Revision : 1.0
// ============================================================================
module pkt_hdr_parser
    import pkt_h::*;
#(
    parameter int DWIDTH    = 64,
    parameter int MAX_WORDS = 256,
    parameter int CNT_W     = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DWIDTH-1:0] in_data,
    input  logic              in_sop,
    input  logic              in_eop,
    output logic              out_en,
    input  logic              out_ready,
    output pkHeadInfo         out_pkt_info,
    output logic [DWIDTH-1:0] out_data,
    output logic [CNT_W-1:0]  drop_cnt
);

    localparam int               WC_W        = $clog2(MAX_WORDS) + 1;
    localparam logic [WC_W-1:0]  c_max_cnt   = WC_W'(MAX_WORDS);
    localparam logic [31:0]      c_max_words = 32'(MAX_WORDS);

    parser_state_e     r_state;
    logic              r_in_ready;
    logic              r_out_en;
    logic              r_discard;
    logic [WC_W-1:0]   r_word_cnt;
    pkHeadInfo         r_hdr;
    logic [DWIDTH-1:0] r_out_data;
    logic [CNT_W-1:0]  r_drop_cnt;

    logic              w_accept;
    logic              w_in_discard;
    pkHeadInfo         w_beat_hdr;
    pkHeadInfo         w_hdr;
    logic [WC_W-1:0]   w_cnt_next;
    logic [16:0]       w_exp;
    logic [31:0]       w_exp32;
    logic [31:0]       w_cnt32;
    logic              w_chk_pass;
    logic              w_good;
    logic [1:0]        w_drop_inc;
    logic [CNT_W:0]    w_drop_sum;

    assign w_accept     = in_valid && r_in_ready;
    assign w_in_discard = (r_state == BODY) && r_discard;
    assign w_beat_hdr   = decode_hdr(in_data);

    // A sop beat is judged against its own header, not the latched one.
    assign w_hdr      = in_sop ? w_beat_hdr : r_hdr;
    assign w_cnt_next = in_sop ? WC_W'(1) : r_word_cnt + WC_W'(1);
    assign w_exp      = ({1'b0, w_hdr.len} + 17'd7) >> 3;
    assign w_exp32    = {15'd0, w_exp};
    assign w_cnt32    = {{(32-WC_W){1'b0}}, w_cnt_next};

`ifdef PKT_PARSER_CHKSUM_EN
    logic w_beat_chk_ok;
    logic r_chk_ok;

    pkt_hdr_chksum u_chksum (
        .i_hdr    (in_data),
        .o_chk_ok (w_beat_chk_ok)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_chk_ok <= 1'b0;
        end else if (w_accept && in_sop) begin
            r_chk_ok <= w_beat_chk_ok;
        end
    end

    assign w_chk_pass = in_sop ? w_beat_chk_ok : r_chk_ok;
`else
    assign w_chk_pass = 1'b1;
`endif

    assign w_good = (w_hdr.len != 16'd0) && (w_exp32 == w_cnt32) &&
                    (w_exp32 <= c_max_words) && w_chk_pass;

    // A sop that truncates a packet and is itself a bad single-word packet costs two drops.
    always_comb begin
        w_drop_inc = 2'd0;
        if (w_accept && (r_state != EMIT) && !w_in_discard) begin
            if (!in_sop && (r_state == IDLE)) begin
                w_drop_inc = 2'd1;
            end else begin
                if (in_sop && (r_state == BODY)) begin
                    w_drop_inc = 2'd1;
                end
                if (in_eop && !w_good) begin
                    w_drop_inc = w_drop_inc + 2'd1;
                end else if (!in_eop && !in_sop && (w_cnt_next == c_max_cnt)) begin
                    w_drop_inc = w_drop_inc + 2'd1;
                end
            end
        end
    end

    assign w_drop_sum = {1'b0, r_drop_cnt} + {{(CNT_W-1){1'b0}}, w_drop_inc};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_drop_cnt <= '0;
        end else if (w_drop_sum[CNT_W]) begin
            r_drop_cnt <= '1;
        end else begin
            r_drop_cnt <= w_drop_sum[CNT_W-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= IDLE;
            r_in_ready <= 1'b0;
            r_out_en   <= 1'b0;
            r_discard  <= 1'b0;
            r_word_cnt <= '0;
            r_hdr      <= '0;
            r_out_data <= '0;
        end else begin
            case (r_state)
                IDLE, BODY: begin
                    r_in_ready <= 1'b1;
                    if (w_accept) begin
                        if (w_in_discard) begin
                            if (in_eop) begin
                                r_discard <= 1'b0;
                                r_state   <= IDLE;
                            end
                        end else if (in_sop || (r_state == BODY)) begin
                            r_word_cnt <= w_cnt_next;
                            if (in_sop) begin
                                r_hdr      <= w_beat_hdr;
                                r_out_data <= '0;
                            end else if (r_word_cnt == WC_W'(1)) begin
                                r_out_data <= in_data;
                            end
                            if (in_eop) begin
                                if (w_good) begin
                                    r_state    <= EMIT;
                                    r_out_en   <= 1'b1;
                                    r_in_ready <= 1'b0;
                                end else begin
                                    r_state <= IDLE;
                                end
                            end else begin
                                r_state <= BODY;
                                if (!in_sop && (w_cnt_next == c_max_cnt)) begin
                                    r_discard <= 1'b1;
                                end
                            end
                        end
                    end
                end
                EMIT: begin
                    r_in_ready <= 1'b0;
                    if (out_ready) begin
                        r_out_en   <= 1'b0;
                        r_in_ready <= 1'b1;
                        r_state    <= IDLE;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign in_ready     = r_in_ready;
    assign out_en       = r_out_en;
    assign out_pkt_info = r_hdr;
    assign out_data     = r_out_data;
    assign drop_cnt     = r_drop_cnt;

endmodule
`default_nettype wire
